// File: rtl/fifo_nibble_pkg.sv
// Shared constants and state type for the nibble FIFO feeder.
package fifo_nibble_pkg;
  localparam int NIB_W     = 4;
  localparam int WORD_NIBS = 8;
  localparam int DEPTH     = 32;
  localparam int DRAIN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    GAP   = 2'd3
  } feeder_state_t;
endpackage

// File: rtl/fifo_nibble_feeder_shifter.sv
// Latched word and remaining-nibble count; presents the LSB nibble and a last flag.
module nibble_shifter
  import fifo_nibble_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [NIB_W*WORD_NIBS-1:0] data,
  input  logic [3:0]                 len,
  input  logic                       shift,
  output logic [NIB_W-1:0]           nib,
  output logic                       last
);
  logic [NIB_W*WORD_NIBS-1:0] shreg_q;
  logic [3:0]                 rem_q;
  logic [3:0]                 len_eff;

  // A length of 0 means a full word; anything above a full word is clamped.
  assign len_eff = (len == 4'd0 || len > 4'(WORD_NIBS)) ? 4'(WORD_NIBS) : len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      rem_q   <= '0;
    end else if (load) begin
      shreg_q <= data;
      rem_q   <= len_eff;
    end else if (shift) begin
      shreg_q <= shreg_q >> NIB_W;
      rem_q   <= rem_q - 4'd1;
    end
  end

  assign nib  = shreg_q[NIB_W-1:0];
  assign last = (rem_q == 4'd1);
endmodule

// File: rtl/fifo_nibble_feeder.sv
// Word-to-nibble FIFO feeder with local occupancy tracking and threshold/timeout flushes.
// Build option FEEDER_STATS_EN adds saturating word/flush/stall counters.
module fifo_nibble_feeder
  import fifo_nibble_pkg::*;
#(
  parameter int DEPTH        = fifo_nibble_pkg::DEPTH,
  parameter int FLUSH_THRESH = 8,
  parameter int TIMEOUT      = 16,
  parameter int FLUSH_HOLD   = 2
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          src_valid_i,
  input  logic [31:0]   src_data_i,
  input  logic [3:0]    src_len_i,
  output logic          src_ready_o,
  output logic          fifo_wr_valid_o,
  output logic [3:0]    fifo_wr_data_o,
  output logic          fifo_flush_o,
  input  logic          fifo_full_i,
`ifdef FEEDER_STATS_EN
  input  logic          stat_clr_i,
  output logic [15:0]   stat_words_o,
  output logic [15:0]   stat_flushes_o,
  output logic [15:0]   stat_stalls_o,
`endif
  output logic [5:0]    pending_o,
  output logic          busy_o,
  output feeder_state_t state_o
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int HW = $clog2(FLUSH_HOLD);

  // Handshake: a word moves when src_valid_i and src_ready_o are both high at
  // a rising clk edge; src_ready_o is registered and never depends on src_valid_i.
  feeder_state_t   state_q, state_d, ret_q, ret_d;
  logic [5:0]      pending_q, pending_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            ready_q, ready_d;
  logic            accept, space, wr, load;
  logic [NIB_W-1:0] nib;
  logic            last;

  function automatic logic flush_due(input logic [5:0] p, input logic [TW-1:0] t);
    return (int'(p) >= FLUSH_THRESH) ||
           (TIMEOUT != 0 && int'(t) == TIMEOUT && p != 6'd0);
  endfunction

  assign accept = src_valid_i & ready_q;
  assign space  = (pending_q < 6'(DEPTH - 1)) && !fifo_full_i;
  assign wr     = (state_q == SHIFT) && space;

  nibble_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .data  (src_data_i),
    .len   (src_len_i),
    .shift (wr),
    .nib   (nib),
    .last  (last)
  );

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_due(pending_q, timer_q)) begin
          state_d = FLUSH;
          ret_d   = IDLE;
          hold_d  = '0;
        end else if (accept) begin
          load    = 1'b1;
          state_d = SHIFT;
          timer_d = '0;
        end else if (pending_q != 6'd0 && int'(timer_q) != TIMEOUT) begin
          timer_d = timer_q + 1'b1;
        end
      end
      SHIFT: begin
        if (wr) begin
          pending_d = pending_q + 6'd1;
          timer_d   = '0;
          if (last) state_d = IDLE;
        end else begin
          // No room: drain the consumer and come back to finish this word.
          state_d = FLUSH;
          ret_d   = SHIFT;
          hold_d  = '0;
        end
      end
      FLUSH: begin
        if (hold_q == HW'(FLUSH_HOLD - 1)) state_d = GAP;
        else                               hold_d  = hold_q + 1'b1;
      end
      GAP: begin
        pending_d = (pending_q > 6'(DRAIN_MAX)) ? pending_q - 6'(DRAIN_MAX) : 6'd0;
        timer_d   = '0;
        state_d   = ret_q;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) && !flush_due(pending_d, timer_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
    end
  end

  assign src_ready_o     = ready_q;
  assign fifo_wr_valid_o = wr;
  assign fifo_wr_data_o  = wr ? nib : 4'd0;
  assign fifo_flush_o    = (state_q == FLUSH);
  assign pending_o       = pending_q;
  assign busy_o          = (state_q != IDLE);
  assign state_o         = state_q;

`ifdef FEEDER_STATS_EN
  logic [15:0] words_q, flushes_q, stalls_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_q   <= '0;
      flushes_q <= '0;
      stalls_q  <= '0;
    end else if (stat_clr_i) begin
      words_q   <= '0;
      flushes_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (accept && words_q != 16'hFFFF) words_q <= words_q + 16'd1;
      if (state_d == FLUSH && state_q != FLUSH && flushes_q != 16'hFFFF)
        flushes_q <= flushes_q + 16'd1;
      if (state_q == SHIFT && !space && stalls_q != 16'hFFFF) stalls_q <= stalls_q + 16'd1;
    end
  end
  assign stat_words_o   = words_q;
  assign stat_flushes_o = flushes_q;
  assign stat_stalls_o  = stalls_q;
`endif
endmodule
